// File: rtl/shift_reg_arbiter.sv
// shift_reg_arbiter
//   Two requesters share one WIDTH-bit shift register. A granted requester's
//   parallel word is loaded and sent MSB first on sout over WIDTH cycles.
//   Back-to-back words leave no idle bubble. A 1-bit round-robin pointer
//   resolves contention.
// Ports:
//   clk        - clock; all state changes on its rising edge
//   rst        - synchronous active-high reset
//   req[1:0]   - level request per requester, held until its gnt is seen
//   ins0/ins1  - parallel words from requester 0 / 1, sampled at load
//   gnt[1:0]   - one-hot grant, high during the first cycle of a word
//   outs       - shared register contents
//   sout       - serial data (outs MSB)
//   sout_valid - sout carries a payload bit
//   busy       - high while shifting
//   done       - high during the last payload bit of a word
module shift_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] ins0,
  input  logic [WIDTH-1:0] ins1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] outs,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           ptr;

  logic             win;
  logic [WIDTH-1:0] win_word;

  // Winner: a lone requester wins outright; on contention the pointer decides.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ptr;
      default: win = 1'b0;
    endcase
    win_word = win ? ins1 : ins0;
  end

  assign sout = outs[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      outs       <= '0;
      gnt        <= '0;
      cnt        <= '0;
      ptr        <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      gnt <= '0;
      // Arbitration happens in IDLE and on the edge that ends the last bit,
      // so a waiting requester follows without a gap.
      if (state == IDLE || cnt == LAST) begin
        if (|req) begin
          state      <= SHIFT;
          outs       <= win_word;
          gnt        <= win ? 2'b10 : 2'b01;
          cnt        <= '0;
          ptr        <= ~win;
          sout_valid <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
        end else begin
          state      <= IDLE;
          outs       <= '0;
          cnt        <= '0;
          sout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      end else begin
        outs <= {outs[WIDTH-2:0], 1'b0};
        cnt  <= cnt + 1'b1;
        done <= (cnt + 1'b1) == LAST;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// tb_shift_reg_arbiter
//   Directed scenarios plus randomized traffic for shift_reg_arbiter
//   (WIDTH=4), checked every cycle against a word-level reference model.
module tb_shift_reg_arbiter;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] ins0 = '0;
  logic [W-1:0] ins1 = '0;
  logic [1:0]   gnt;
  logic [W-1:0] outs;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  shift_reg_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ins0       (ins0),
    .ins1       (ins1),
    .gnt        (gnt),
    .outs       (outs),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: the word in flight and the index of the bit on sout.
  bit m_active = 0;
  int m_k      = 0;
  int m_word   = 0;
  int m_ptr    = 0;
  int m_gnt    = 0;
  bit hold_req = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      m_active = 0; m_k = 0; m_word = 0; m_ptr = 0; m_gnt = 0;
    end else if (!m_active || m_k == W - 1) begin
      if (req != 2'b00) begin
        if (req == 2'b11) w = m_ptr;
        else              w = req[1] ? 1 : 0;
        m_word   = (w == 1) ? int'(ins1) : int'(ins0);
        m_k      = 0;
        m_active = 1;
        m_gnt    = 1 << w;
        m_ptr    = 1 - w;
      end else begin
        m_active = 0; m_k = 0; m_word = 0; m_gnt = 0;
      end
    end else begin
      m_k++;
      m_gnt = 0;
    end
  endtask

  // One clock: model update at the edge, compare 1 time unit later, then
  // requesters that see their grant drop req (unless told to hold).
  task automatic step();
    int exp_outs;
    @(posedge clk);
    model_edge();
    #1;
    exp_outs = m_active ? ((m_word << m_k) & MASK) : 0;
    check_eq("outs",       32'(outs),       32'(exp_outs));
    check_eq("sout",       32'(sout),       32'((exp_outs >> (W - 1)) & 1));
    check_eq("sout_valid", 32'(sout_valid), 32'(m_active));
    check_eq("busy",       32'(busy),       32'(m_active));
    check_eq("done",       32'(done),       32'(m_active && m_k == W - 1));
    check_eq("gnt",        32'(gnt),        32'(m_gnt));
    if (!hold_req) req = req & ~gnt;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  logic [7:0] ser;
  logic [7:0] gseq;
  int         nvalid;

  initial begin
    // Reset from an arbitrary state.
    req = 2'b11; ins0 = 4'b1111; ins1 = 4'b1111;
    step(); step();
    req = 2'b00;
    do_reset(2);
    check_eq("rst_outs", 32'(outs), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Single request, word 1010.
    req = 2'b01; ins0 = 4'b1010; ser = '0;
    for (int i = 0; i < W; i++) begin
      step();
      if (i == 0) check_eq("single_gnt", 32'(gnt), 32'd1);
      ins0 = 4'b0101;
      ser = {ser[6:0], sout};
    end
    check_eq("single_ser", 32'(ser[3:0]), 32'hA);
    check_eq("single_done", 32'(done), 32'd1);
    step();
    check_eq("single_idle", 32'(busy), 32'd0);

    // Contention back-to-back after reset.
    do_reset(1);
    req = 2'b11; ins0 = 4'b1100; ins1 = 4'b0111; ser = '0; nvalid = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      ser = {ser[6:0], sout};
      nvalid += int'(sout_valid);
      if (i == W) check_eq("contend_gnt2", 32'(gnt), 32'd2);
    end
    check_eq("contend_ser", 32'(ser), 32'hC7);
    check_eq("contend_valid", 32'(nvalid), 32'd8);
    step();

    // Fairness with both requests held.
    do_reset(1);
    hold_req = 1; req = 2'b11; gseq = '0;
    for (int i = 0; i < 4 * W; i++) begin
      ins0 = 4'($urandom); ins1 = 4'($urandom);
      step();
      if (i % W == 0) gseq = {gseq[5:0], gnt};
    end
    check_eq("fair_seq", 32'(gseq), 32'h66);
    hold_req = 0; req = 2'b00;
    for (int i = 0; i < W + 1; i++) step();

    // Late request from requester 1 during bit 2.
    do_reset(1);
    req = 2'b01; ins0 = 4'b1001; ins1 = 4'b0110;
    step(); step(); step();
    req = 2'b10;
    step();
    check_eq("late_done", 32'(done), 32'd1);
    check_eq("late_nognt", 32'(gnt), 32'd0);
    step();
    check_eq("late_gnt", 32'(gnt), 32'd2);
    for (int i = 0; i < W; i++) step();

    // Reset mid-word.
    do_reset(1);
    req = 2'b01; ins0 = 4'b1010;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_outs", 32'(outs), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    req = 2'b11;
    step();
    check_eq("midrst_gnt", 32'(gnt), 32'd1);
    for (int i = 0; i < 2 * W; i++) step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++)
        if (!req[r] && $urandom_range(0, 3) == 0) req[r] = 1'b1;
      ins0 = 4'($urandom);
      ins1 = 4'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_arbiter.md
SHIFT_REG_ARBITER -- requirements
Module: shift_reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the shared shift register width in bits (legal range WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 2 bits: level request per requester; requester i holds req[i] high until it sees gnt[i].
REQ-005 The block SHALL have port ins0, input, WIDTH bits: parallel word from requester 0.
REQ-006 The block SHALL have port ins1, input, WIDTH bits: parallel word from requester 1.
REQ-007 The block SHALL have port gnt, output, 2 bits: registered one-hot grant, high for one cycle per accepted word.
REQ-008 The block SHALL have port outs, output, WIDTH bits: current shared register contents.
REQ-009 The block SHALL have port sout, output, 1 bit: serial data, equal to outs[WIDTH-1].
REQ-010 The block SHALL have port sout_valid, output, 1 bit: sout carries a valid payload bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-012 The block SHALL have port done, output, 1 bit: high during the last payload bit of a word.

Function
REQ-013 The block SHALL implement two states: IDLE and SHIFT, plus a bit counter of $clog2(WIDTH) bits and a 1-bit round-robin pointer.
REQ-014 In IDLE, at a rising edge with req != 0, the block SHALL load the winner's ins word into the register, set gnt to the winner's one-hot code, clear the counter, and enter SHIFT.
REQ-015 Arbitration: single request wins outright; with both requesting, the requester indicated by the pointer wins; the pointer then points at the non-winner.
REQ-016 In SHIFT, the block SHALL hold sout_valid=1 and busy=1; each edge shifts outs left by one, inserting 0 at bit 0, and increments the counter; the payload is therefore sent MSB first over exactly WIDTH cycles.
REQ-017 gnt SHALL be high only in the first SHIFT cycle (the cycle after the load edge) and 00 at all other times.
REQ-018 done SHALL be high only in the SHIFT cycle where counter == WIDTH-1.
REQ-019 At the edge ending the done cycle, the block SHALL re-arbitrate: if req != 0 (excluding nothing), load the next word and stay in SHIFT with no idle bubble; otherwise go to IDLE with outs = 0.
REQ-020 req SHALL be sampled only in IDLE and at the done edge; requests at other SHIFT edges are ignored (not latched), relying on requesters holding req.
REQ-021 ins0/ins1 SHALL be sampled only at the load edge; later changes do not affect the word in flight.
REQ-022 In IDLE: sout_valid=0, busy=0, done=0, gnt=00.

Reset
REQ-023 With rst high at a rising edge, the block SHALL enter IDLE, set outs=0, sout=0, gnt=00, sout_valid=0, busy=0, done=0, counter=0, pointer=0 (requester 0 favoured), regardless of state.
REQ-024 Reset mid-word SHALL discard the word in flight; no resumption and no grant is reissued for it.
REQ-025 rst SHALL take priority over all requests at the same edge.

Verification (WIDTH=4)
REQ-026 Reset: rst high 2 cycles from arbitrary state -> outs=0000, gnt=00, sout=0, sout_valid=0, busy=0, done=0.
REQ-027 Single request: req=01, ins0=1010 -> gnt=01 for one cycle; sout=1,0,1,0 over 4 valid cycles; done on 4th; busy low afterwards with req dropped.
REQ-028 Contention back-to-back: req=11 held, ins0=1100, ins1=0111 after reset -> gnt=01 with 1,1,0,0 then immediately gnt=10 with 0,1,1,1; 8 consecutive sout_valid cycles, no gap.
REQ-029 Fairness: req=11 held for 4 words -> grants alternate 01,10,01,10.
REQ-030 Late request: req1 raised during bit 2 of requester-0 word -> no effect until done edge; gnt=10 in cycle directly after done.
REQ-031 Reset mid-operation: rst pulsed during bit 2 of word 1010 -> next cycle all outputs zero, busy=0; with req=11 afterwards, gnt=01 first.
